// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bus between the control FSM and the mult/div sequencer.
interface muldiv_sequencer_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control side: issues requests, observes status and HI/LO.
    modport master (
        output start, op, operand_a, operand_b,
        input  busy, done, div_zero, hi, lo
    );

    // Sequencer side.
    modport slave (
        input  start, op, operand_a, operand_b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Bit-serial signed multiply / restoring divide on operand magnitudes,
// with sign fix-up in a final cycle. Owns the architectural HI/LO registers.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic              clk,
    input  logic              reset,
    muldiv_sequencer_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam int unsigned ACC_W = 2 * WIDTH;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIXUP,
        ST_DZERO
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    // Multiplicand magnitude for mult, divisor magnitude for div.
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    // Mult: {partial product high, multiplier/low}. Div: {remainder, dividend/quotient}.
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               op_q, op_d;
    logic               sign_a_q, sign_a_d;
    logic               neg_q, neg_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic               last_iter;
    logic [WIDTH:0]     mult_sum;
    logic [WIDTH:0]     div_trial;
    logic [ACC_W-1:0]   prod_fix;
    logic [WIDTH-1:0]   quot, rem;

    assign abs_a     = bus.operand_a[WIDTH-1] ? -bus.operand_a : bus.operand_a;
    assign abs_b     = bus.operand_b[WIDTH-1] ? -bus.operand_b : bus.operand_b;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (!bus.op)                         state_d = ST_MULT;
                    else if (bus.operand_b == '0)        state_d = ST_DZERO;
                    else                                 state_d = ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (last_iter) state_d = ST_FIXUP;
            end
            ST_FIXUP, ST_DZERO: state_d = ST_IDLE;
            default:            state_d = ST_IDLE;
        endcase
    end

    // Datapath step and registered outputs for the current state.
    always_comb begin
        cnt_d     = cnt_q;
        opnd_d    = opnd_q;
        acc_d     = acc_q;
        op_d      = op_q;
        sign_a_d  = sign_a_q;
        neg_d     = neg_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mult_sum  = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        div_trial = {acc_q[ACC_W-1:WIDTH-1]} - {1'b0, opnd_q};
        prod_fix  = neg_q ? -acc_q : acc_q;
        quot      = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem       = sign_a_q ? -acc_q[ACC_W-1:WIDTH] : acc_q[ACC_W-1:WIDTH];

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op;
                    sign_a_d = bus.operand_a[WIDTH-1];
                    neg_d    = bus.operand_a[WIDTH-1] ^ bus.operand_b[WIDTH-1];
                    opnd_d   = bus.op ? abs_b : abs_a;
                    acc_d    = {WIDTH'(0), bus.op ? abs_a : abs_b};
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    dz_d     = 1'b0;
                end
            end
            ST_MULT: begin
                acc_d = {mult_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
            end
            ST_DIV: begin
                // Shift remainder left, trial subtract, keep only if non-negative.
                if (!div_trial[WIDTH]) acc_d = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                   acc_d = {acc_q[ACC_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
            end
            ST_FIXUP: begin
                if (op_q) begin
                    lo_d = quot;
                    hi_d = rem;
                end else begin
                    {hi_d, lo_d} = prod_fix;
                end
                done_d = 1'b1;
                busy_d = 1'b0;
            end
            ST_DZERO: begin
                done_d = 1'b1;
                dz_d   = 1'b1;
                busy_d = 1'b0;
            end
            default: ;
        endcase
    end

    // Datapath and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            op_q     <= 1'b0;
            sign_a_q <= 1'b0;
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multicycle sequencer for the signed mult/div resource; one bit per clock, shift-add multiply and restoring divide on operand magnitudes, sign fix-up at the end.
- Owns the architectural HI/LO registers read by mfhi/mflo.
- Driven by the main control FSM with a start/busy/done handshake; div-by-zero is reported as a status flag, not an exception.

Parameters:
WIDTH, 32, operand width; HI/LO are WIDTH bits each; legal for WIDTH >= 2.

Ports:
clk  input  1  system clock; one clock domain, all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  1  0 = mult, 1 = div; sampled with start.
operand_a  input  WIDTH  rs value, signed (multiplicand or dividend); sampled with start.
operand_b  input  WIDTH  rt value, signed (multiplier or divisor); sampled with start.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse when HI/LO (or div_zero) is updated.
div_zero  output  1  sticky; set by div with operand_b == 0; cleared on next accepted start.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high (reset).
- Reset: state = IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, counter = 0.
- Reset mid-operation aborts the operation; HI/LO are still cleared; no done pulse.
- States: IDLE, MULT, DIV, FIXUP, DZERO.
- IDLE:
  - start = 1 at edge E0: latch |a|, |b| and the sign flags, clear div_zero, counter = 0, busy = 1.
  - Next state: MULT if op = 0; DIV if op = 1 and b != 0; DZERO if op = 1 and b == 0.
  - start = 0: hold.
- MULT: each edge adds the shifted multiplicand when the current multiplier bit is 1, then shifts; counter++.
  - After WIDTH iterations (edges E1..E_WIDTH): go to FIXUP.
- DIV: restoring division, one quotient bit per edge (shift remainder, trial subtract, restore if negative).
  - After WIDTH iterations: go to FIXUP.
- FIXUP (edge E_WIDTH+1): apply signs, write HI/LO, done = 1 for one cycle, busy = 0, next state IDLE.
  - mult: {hi, lo} = signed 2*WIDTH-bit product; negate the magnitude product if sign(a) XOR sign(b).
  - div: lo = quotient truncated toward zero (negated if signs differ); hi = remainder carrying the dividend's sign.
  - div of -2^(WIDTH-1) by -1: lo = 0x80000000 (wrapped), hi = 0; no flag raised.
- DZERO (edge E1): done = 1, div_zero = 1, busy = 0; hi/lo unchanged; next state IDLE.
- Timing: busy is high in the cycles between E0 and the completing edge.
  - Normal latency: done visible after edge E0 + WIDTH + 1 (33 edges for WIDTH = 32).
  - Div-by-zero latency: done visible after E0 + 1.
- start while busy is ignored: no latch, no queueing, no effect on the running operation or its operands.
- start in the cycle done is high is accepted; back-to-back operations are allowed.
- Input changes on operand_a, operand_b or op after E0 have no effect.
- hi/lo hold their value between operations and change only in FIXUP or on reset.
- done is never asserted in the same cycle as busy.

Test Plan:
- mult 7 x -3 (0x00000007, 0xFFFFFFFD) -> done pulses 33 edges after start; hi = 0xFFFFFFFF, lo = 0xFFFFFFEB; busy low with done.
- mult 0x80000000 x 0x80000000 -> hi = 0x40000000, lo = 0x00000000; then div -7 / 2 back-to-back (start in the done cycle) -> lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- div 100 / 0 -> done 1 edge after start, div_zero = 1, hi/lo keep the previous values; next mult 2 x 3 clears div_zero, lo = 6, hi = 0.
- div 0x80000000 / 0xFFFFFFFF -> lo = 0x80000000, hi = 0, div_zero = 0.
- start mult 5 x 5; pulse start with op = div, b = 0 at iteration 10 -> ignored; result lo = 25, hi = 0, div_zero = 0, exactly one done pulse.
- Assert reset at iteration 15 of div 50 / 7 -> next cycle busy = 0, hi = lo = 0, state IDLE, no done pulse; a fresh div 50 / 7 -> lo = 7, hi = 1.
